cpu5_ifetch: RTL and testbench

Instruction-fetch front end for the 5-stage pipelined CPU. It owns the program counter, issues word reads to the synchronous instruction memory and buffers returned words in a small prefetch queue. It presents {pc, instr} to the decode stage under a valid/ready handshake and flushes on branch/jump redirects from execute. It sits directly upstream of decode and replaces the direct PC-to-imem path.

---
 rtl/cpu5_ifetch.sv | 157 +++++++++++++++
 tb/tb_cpu5_ifetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_ifetch.sv
// cpu5_ifetch: instruction-fetch front end. Owns the PC, issues word reads to
// a synchronous, never-stalling instruction memory, buffers returned words in
// a DEPTH-entry prefetch queue and hands {pc, instr} to decode under
// valid/ready. A br_taken redirect flushes everything and refetches.
//
// Optional feature macro: CPU5_IFETCH_PERF_EN adds perf_fetched/perf_flushes.
//
// Handshake: decode consumes the head on a rising edge where id_valid and
// id_ready are both high; id_valid never depends on id_ready, and the head
// stays stable until consumed or flushed.
module cpu5_ifetch #(
  parameter int unsigned             ADDR_W   = 32,
  parameter int unsigned             DEPTH    = 4,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target
`ifdef CPU5_IFETCH_PERF_EN
  , output logic [31:0]     perf_fetched
  , output logic [31:0]     perf_flushes
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  // Fetch state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  // Prefetch queue
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q    [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d    [DEPTH];
  logic [31:0]       mem_instr_q [DEPTH];
  logic [31:0]       mem_instr_d [DEPTH];

  logic push, pop;

  // Low target bits are architecturally ignored.
  logic unused_br_lo;
  assign unused_br_lo = ^br_target[1:0];

  // Request/handshake outputs: the outstanding read is counted so a returning
  // word always has a free slot.
  always_comb begin
    imem_req  = (({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C) && !br_taken;
    imem_addr = pc_q;
    id_valid  = (count_q != '0);
    id_instr  = mem_instr_q[rd_ptr_q];
    id_pc     = mem_pc_q[rd_ptr_q];
    push      = inflight_q && !br_taken;
    pop       = id_valid && id_ready && !br_taken;
  end

  // Next-state: redirect wins over fetch, push and pop.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    mem_pc_d      = mem_pc_q;
    mem_instr_d   = mem_instr_q;

    if (br_taken) begin
      pc_d     = {br_target[ADDR_W-1:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (imem_req) begin
        pc_d          = pc_q + ADDR_W'(4);
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (push) begin
        mem_pc_d[wr_ptr_q]    = inflight_pc_q;
        mem_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers; entries reset to zero so the head is never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      mem_pc_q      <= mem_pc_d;
      mem_instr_q   <= mem_instr_d;
    end
  end

`ifdef CPU5_IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Event counters for pushes and redirect edges; both wrap naturally.
  always_comb begin
    perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_flushes_d = perf_flushes_q + (br_taken ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_cpu5_ifetch.sv
// Directed bench for cpu5_ifetch (ADDR_W=32, DEPTH=4, RESET_PC=0).
// The memory model returns the word equal to its byte address one cycle
// after each request.
module tb_cpu5_ifetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic        br_taken;
  logic [31:0] br_target;
`ifdef CPU5_IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  cpu5_ifetch #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready),
    .br_taken   (br_taken),
    .br_target  (br_target)
`ifdef CPU5_IFETCH_PERF_EN
    , .perf_fetched (perf_fetched)
    , .perf_flushes (perf_flushes)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word = address, poison when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Consume expected PCs from the scoreboard: one per edge with ready high.
  task automatic stream_check(input string tag, input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, {31'b0, id_valid}, 32'd1);
      check_eq({tag, "_pc"}, id_pc, e);
      check_eq({tag, "_instr"}, id_instr, e);
    end
  endtask

  initial begin
    reset      = 1'b0;
    id_ready   = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;
    imem_rdata = 32'h0;

    // Reset state
    #2;
    check_eq("rst_req",   {31'b0, imem_req}, 32'd1);
    check_eq("rst_addr",  imem_addr, 32'h0);
    check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("rst_pc",    id_pc, 32'h0);
    check_eq("rst_instr", id_instr, 32'h0);

    @(posedge clk);
    #1;
    reset = 1'b1;

    // Edge 1: first request issued, nothing visible yet
    tick();
    check_eq("e1_valid", {31'b0, id_valid}, 32'd0);
    check_eq("e1_addr",  imem_addr, 32'h4);

    // Edges 2..7: one instruction per cycle from PC 0
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
    stream_check("run", 6);

    // Stall: queue fills (0x14 head + 0x18,0x1C,0x20), requests stop
    id_ready = 1'b0;
    tick();
    check_eq("stall1_req", {31'b0, imem_req}, 32'd1);
    tick();
    check_eq("stall_drop_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check_eq("full_req",   {31'b0, imem_req}, 32'd0);
    check_eq("full_valid", {31'b0, id_valid}, 32'd1);
    check_eq("full_head",  id_pc, 32'h14);
    check_eq("full_addr",  imem_addr, 32'h24);

    // Release: in-order, no gaps or duplicates
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h18 + 32'(4 * i));
    stream_check("drain", 5);

    // Build 3 queued + 1 inflight, then redirect to 0x103
    id_ready = 1'b0;
    tick();
    check_eq("pre_fl_req",  {31'b0, imem_req}, 32'd0);
    check_eq("pre_fl_head", id_pc, 32'h28);
    br_taken  = 1'b1;
    br_target = 32'h103;
    #1;
    check_eq("br_blocks_req", {31'b0, imem_req}, 32'd0);
    tick();
    br_taken = 1'b0;
    id_ready = 1'b1;
    #1;
    check_eq("fl_valid", {31'b0, id_valid}, 32'd0);
    check_eq("fl_addr",  imem_addr, 32'h100);
    check_eq("fl_req",   {31'b0, imem_req}, 32'd1);
    tick();
    check_eq("fl1_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check_eq("fl2_valid", {31'b0, id_valid}, 32'd1);
    check_eq("fl2_pc",    id_pc, 32'h100);
    check_eq("fl2_instr", id_instr, 32'h100);
    tick();
    check_eq("fl3_pc", id_pc, 32'h104);

    // Redirect on the same edge as a pop: pop ignored
    br_taken  = 1'b1;
    br_target = 32'h200;
    #1;
    tick();
    br_taken = 1'b0;
    #1;
    check_eq("flpop_valid", {31'b0, id_valid}, 32'd0);
    check_eq("flpop_addr",  imem_addr, 32'h200);
    tick();
    check_eq("flpop1_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check_eq("flpop2_valid", {31'b0, id_valid}, 32'd1);
    check_eq("flpop2_pc",    id_pc, 32'h200);
    tick();
    check_eq("flpop3_pc", id_pc, 32'h204);

    // Asynchronous reset with a read outstanding
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, id_valid}, 32'd0);
    check_eq("arst_addr",  imem_addr, 32'h0);
    check_eq("arst_req",   {31'b0, imem_req}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rr1_valid", {31'b0, id_valid}, 32'd0);
    check_eq("rr1_addr",  imem_addr, 32'h4);
    tick();
    check_eq("rr2_valid", {31'b0, id_valid}, 32'd1);
    check_eq("rr2_pc",    id_pc, 32'h0);
`ifdef CPU5_IFETCH_PERF_EN
    check_eq("perf_fetch0", perf_fetched, 32'd1);
    check_eq("perf_flush0", perf_flushes, 32'd0);
`endif

    // Redirect near the top of memory: low bits dropped, PC wraps to 0
    br_taken  = 1'b1;
    br_target = 32'hFFFF_FFFE;
    #1;
    tick();
    br_taken = 1'b0;
    #1;
    check_eq("wrap_addr0",  imem_addr, 32'hFFFF_FFFC);
    check_eq("wrap_valid0", {31'b0, id_valid}, 32'd0);
    tick();
    check_eq("wrap_addr1", imem_addr, 32'h0);
    tick();
    check_eq("wrap_pc",    id_pc, 32'hFFFF_FFFC);
    check_eq("wrap_instr", id_instr, 32'hFFFF_FFFC);
`ifdef CPU5_IFETCH_PERF_EN
    check_eq("perf_fetch1", perf_fetched, 32'd2);
    check_eq("perf_flush1", perf_flushes, 32'd1);
`endif
    tick();
    check_eq("wrap_next_pc", id_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
